bist_ctrl: RTL and testbench
============================

BIST_CTRL -- requirements
Module: bist_ctrl

Interface
REQ-001 Parameter N_PATTERNS, default 127: number of LFSR patterns applied per test run (range 2..127).
REQ-002 Parameter GOLDEN_SIG, default 7'h2A: expected MISR signature after a fault-free run.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 start  input  1  level request to begin a test run.
REQ-006 abort  input  1  cancels a run in progress.
REQ-007 lfsr_x  input  7  current LFSR state, used for lock-up detection.
REQ-008 misr_sig  input  7  current MISR signature.
REQ-009 lfsr_enable  output  1  advances the LFSR.
REQ-010 lfsr_reset  output  1  active-high seed or reset pulse to the LFSR.
REQ-011 misr_enable  output  1  MISR compaction enable.
REQ-012 misr_reset  output  1  active-high MISR clear pulse.
REQ-013 test_mode  output  1  selects LFSR patterns as the circuit-under-test inputs.
REQ-014 busy  output  1  a run is in progress.
REQ-015 done  output  1  the run has finished and the result is valid.
REQ-016 pass  output  1  the signature matched; valid only while done=1.
REQ-017 error  output  1  an LFSR all-zero lock-up was detected.
REQ-018 pattern_cnt  output  7  number of patterns applied in the current run.

Function
REQ-019 The block SHALL be a registered Moore FSM with states IDLE, INIT, RUN, FLUSH, COMPARE and DONE; all outputs SHALL be decoded from the registered state and counters.
REQ-020 IDLE: all outputs 0; start=1 -> INIT on the next edge.
REQ-021 INIT, one cycle: lfsr_reset=1, misr_reset=1, test_mode=1, busy=1, pattern_cnt cleared to 0; -> RUN.
REQ-022 RUN: lfsr_enable=1, misr_enable=1, test_mode=1, busy=1; pattern_cnt increments by 1 per cycle; when pattern_cnt==N_PATTERNS-1 -> FLUSH; pattern_cnt SHALL never wrap.
REQ-023 FLUSH, one cycle: lfsr_enable=0, misr_enable=1, test_mode=1, busy=1; absorbs the final response; -> COMPARE.
REQ-024 COMPARE, one cycle: busy=1; the pass register loads (misr_sig==GOLDEN_SIG); -> DONE.
REQ-025 DONE: done=1, busy=0, test_mode=0; pass and pattern_cnt held; start=1 -> INIT (new run, done, pass and error cleared); otherwise stay.
REQ-026 Latency: start sampled in IDLE at edge t SHALL give INIT at t+1, RUN for exactly N_PATTERNS cycles, and done=1 at t+N_PATTERNS+4.
REQ-027 In RUN, lfsr_x==0 (lock-up) SHALL go directly to DONE with error=1 and pass=0, skipping FLUSH and COMPARE.
REQ-028 abort=1 in any state except IDLE SHALL go to IDLE on the next edge, clearing done, pass and error; abort SHALL have priority over start and over lock-up.
REQ-029 start in INIT, RUN, FLUSH or COMPARE SHALL be ignored.
REQ-030 start and abort both asserted in IDLE SHALL keep the FSM in IDLE.

Reset
REQ-031 reset=0 at a rising edge SHALL force IDLE, pattern_cnt=0, pass=0, error=0, done=0, and every output 0, from any state including mid-RUN.
REQ-032 reset SHALL take priority over abort and start.

Structure
REQ-033 The package bist_pkg SHALL hold the state enumeration, the 7-bit width constant, and the default N_PATTERNS and GOLDEN_SIG values.
REQ-034 The pattern counter SHALL be a sub-module, bist_pattern_counter, with clear, increment enable and terminal-count output.
REQ-035 The LFSR, the MISR and the circuit under test are external; the block only drives their controls.

Verification
REQ-036 Nominal run: N_PATTERNS=127, start pulsed at t, misr_sig=7'h2A at COMPARE -> done=1 at t+131, pass=1, error=0, pattern_cnt=126, lfsr_enable high for exactly 127 cycles.
REQ-037 Signature mismatch: same stimulus, misr_sig=7'h2B at COMPARE -> done=1, pass=0, error=0.
REQ-038 Lock-up: lfsr_x forced to 0 on the 10th RUN cycle -> the next state is DONE, error=1, pass=0, and FLUSH is never entered.
REQ-039 Abort: abort=1 on the 50th RUN cycle -> IDLE next cycle, all outputs 0; a later start gives a full 127-pattern run.
REQ-040 Reset mid-run: reset=0 for one edge during RUN -> all outputs 0 and pattern_cnt=0; start held during INIT or RUN has no effect on the cycle count.
REQ-041 Rerun from DONE: start=1 while done=1 -> INIT next cycle, done, pass and error cleared, lfsr_reset=1 and misr_reset=1 for exactly one cycle.

Source files
------------

// File: rtl/bist_pkg.sv
// bist_pkg: shared definitions for the BIST controller.
// Holds the datapath width, default run parameters, the FSM state encoding
// and the state-to-control decode used to build the registered outputs.
package bist_pkg;

  localparam int BIST_W = 7;
  localparam int DEF_N_PATTERNS = 127;
  localparam logic [BIST_W-1:0] DEF_GOLDEN_SIG = 7'h2A;

  // State encoding kept as plain constants for legacy tool compatibility.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_INIT    = 3'd1;
  localparam state_t ST_RUN     = 3'd2;
  localparam state_t ST_FLUSH   = 3'd3;
  localparam state_t ST_COMPARE = 3'd4;
  localparam state_t ST_DONE    = 3'd5;

  typedef struct packed {
    logic lfsr_enable;
    logic lfsr_reset;
    logic misr_enable;
    logic misr_reset;
    logic test_mode;
    logic busy;
    logic done;
  } ctrl_t;

  // Moore decode: control outputs depend only on the state.
  function automatic ctrl_t decode_ctrl(input state_t st);
    ctrl_t c;
    c = '{default: 1'b0};
    case (st)
      ST_IDLE: c = '{default: 1'b0};
      ST_INIT: begin
        c.lfsr_reset = 1'b1;
        c.misr_reset = 1'b1;
        c.test_mode  = 1'b1;
        c.busy       = 1'b1;
      end
      ST_RUN: begin
        c.lfsr_enable = 1'b1;
        c.misr_enable = 1'b1;
        c.test_mode   = 1'b1;
        c.busy        = 1'b1;
      end
      ST_FLUSH: begin
        c.misr_enable = 1'b1;
        c.test_mode   = 1'b1;
        c.busy        = 1'b1;
      end
      ST_COMPARE: c.busy = 1'b1;
      ST_DONE:    c.done = 1'b1;
      default:    c = '{default: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bist_if.sv
// bist_if: bundles the BIST request/status signals and the LFSR/MISR
// control and observation lines.
//   master : test requester / environment (drives start, abort, lfsr_x, misr_sig)
//   slave  : bist_ctrl (drives LFSR/MISR controls and run status)
interface bist_if;
  import bist_pkg::*;

  logic              start;
  logic              abort;
  logic [BIST_W-1:0] lfsr_x;
  logic [BIST_W-1:0] misr_sig;
  logic              lfsr_enable;
  logic              lfsr_reset;
  logic              misr_enable;
  logic              misr_reset;
  logic              test_mode;
  logic              busy;
  logic              done;
  logic              pass;
  logic              error;
  logic [BIST_W-1:0] pattern_cnt;

  modport master (
    output start, abort, lfsr_x, misr_sig,
    input  lfsr_enable, lfsr_reset, misr_enable, misr_reset,
    input  test_mode, busy, done, pass, error, pattern_cnt
  );

  modport slave (
    input  start, abort, lfsr_x, misr_sig,
    output lfsr_enable, lfsr_reset, misr_enable, misr_reset,
    output test_mode, busy, done, pass, error, pattern_cnt
  );

endinterface

// File: rtl/bist_pattern_counter.sv
// bist_pattern_counter: saturating pattern counter for one BIST run.
//   clk, reset : clock and synchronous active-low reset
//   clr        : load zero (wins over inc)
//   inc        : advance by one; ignored once terminal count is reached
//   cnt        : current count
//   tc         : count equals TERMINAL
module bist_pattern_counter
  import bist_pkg::*;
#(
  parameter int W        = BIST_W,
  parameter int TERMINAL = DEF_N_PATTERNS - 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] TC_VAL = W'(TERMINAL);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc  = (cnt_q == TC_VAL);
  assign cnt = cnt_q;

  // Next count: holding at terminal count keeps the counter from wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {W{1'b0}};
    end else if (inc && !tc) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bist_ctrl.sv
// bist_ctrl: Moore FSM sequencing one LFSR/MISR BIST run
// (IDLE -> INIT -> RUN -> FLUSH -> COMPARE -> DONE).
//   clk, reset : clock and synchronous active-low reset
//   bus        : bist_if.slave -- start/abort requests, LFSR state and MISR
//                signature in; LFSR/MISR controls, busy/done/pass/error and
//                pattern_cnt out. All outputs come straight from flops.
module bist_ctrl
  import bist_pkg::*;
#(
  parameter int                N_PATTERNS = DEF_N_PATTERNS,
  parameter logic [BIST_W-1:0] GOLDEN_SIG = DEF_GOLDEN_SIG
) (
  input  logic clk,
  input  logic reset,
  bist_if.slave bus
);

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   pass_q, pass_d;
  logic   error_q, error_d;

  logic              cnt_clr_s;
  logic              cnt_inc_s;
  logic              tc_s;
  logic              lockup_s;
  logic [BIST_W-1:0] cnt_s;

  assign lockup_s = (bus.lfsr_x == {BIST_W{1'b0}});

  // Counter clears on the way into IDLE/INIT so both show zero.
  assign cnt_clr_s = (state_d == ST_IDLE) || (state_d == ST_INIT);
  assign cnt_inc_s = (state_q == ST_RUN);

  bist_pattern_counter #(
    .W        (BIST_W),
    .TERMINAL (N_PATTERNS - 1)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr_s),
    .inc   (cnt_inc_s),
    .cnt   (cnt_s),
    .tc    (tc_s)
  );

  // Next-state logic: abort beats everything outside IDLE, lock-up beats terminal count.
  always_comb begin
    state_d = state_q;
    if ((state_q != ST_IDLE) && bus.abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start && !bus.abort) state_d = ST_INIT;
          else                         state_d = ST_IDLE;
        end
        ST_INIT: state_d = ST_RUN;
        ST_RUN: begin
          if (lockup_s)  state_d = ST_DONE;
          else if (tc_s) state_d = ST_FLUSH;
          else           state_d = ST_RUN;
        end
        ST_FLUSH:   state_d = ST_COMPARE;
        ST_COMPARE: state_d = ST_DONE;
        ST_DONE: begin
          if (bus.start) state_d = ST_INIT;
          else           state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Result flags: cleared on leaving a result, loaded at COMPARE or on lock-up.
  always_comb begin
    pass_d  = pass_q;
    error_d = error_q;
    if ((state_d == ST_IDLE) || (state_d == ST_INIT)) begin
      pass_d  = 1'b0;
      error_d = 1'b0;
    end else if (state_q == ST_COMPARE) begin
      pass_d  = (bus.misr_sig == GOLDEN_SIG);
      error_d = error_q;
    end else if ((state_q == ST_RUN) && (state_d == ST_DONE)) begin
      pass_d  = 1'b0;
      error_d = 1'b1;
    end else begin
      pass_d  = pass_q;
      error_d = error_q;
    end
  end

  // Decoding from the next state lets the controls sit in flops with Moore timing.
  always_comb begin
    ctrl_d = decode_ctrl(state_d);
  end

  // State, result and control registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pass_q  <= 1'b0;
      error_q <= 1'b0;
      ctrl_q  <= '{default: 1'b0};
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      error_q <= error_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.lfsr_enable = ctrl_q.lfsr_enable;
  assign bus.lfsr_reset  = ctrl_q.lfsr_reset;
  assign bus.misr_enable = ctrl_q.misr_enable;
  assign bus.misr_reset  = ctrl_q.misr_reset;
  assign bus.test_mode   = ctrl_q.test_mode;
  assign bus.busy        = ctrl_q.busy;
  assign bus.done        = ctrl_q.done;
  assign bus.pass        = pass_q;
  assign bus.error       = error_q;
  assign bus.pattern_cnt = cnt_s;

endmodule

// File: tb/tb_bist_ctrl.sv
// tb_bist_ctrl: scoreboard bench for bist_ctrl. Each started run pushes its
// expected outcome; a negedge monitor pops and compares when done rises.
module tb_bist_ctrl;
  import bist_pkg::*;

  localparam int          NP   = 127;
  localparam logic [6:0]  GOLD = 7'h2A;

  logic clk = 1'b0;
  logic reset;

  bist_if bus();

  bist_ctrl #(.N_PATTERNS(NP), .GOLDEN_SIG(GOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   start_cyc;
    int   lat;
    logic pass;
    logic err;
    logic chk_cnt;
    int   cnt;
    int   len;
    logic flush;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   len_cnt = 0;
  logic flush_seen = 1'b0;
  logic done_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] outs();
    return {bus.lfsr_enable, bus.lfsr_reset, bus.misr_enable, bus.misr_reset,
            bus.test_mode, bus.busy, bus.done, bus.pass, bus.error, bus.pattern_cnt};
  endfunction

  task automatic push_run(input int lat, input logic p, input logic e, input logic cc,
                          input int cnt, input int len, input logic fl);
    exp_t x;
    x.start_cyc = cyc; x.lat = lat; x.pass = p; x.err = e;
    x.chk_cnt = cc; x.cnt = cnt; x.len = len; x.flush = fl;
    sb.push_back(x);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: tracks LFSR-enable cycles and FLUSH per run, scores each done.
  always @(negedge clk) begin
    exp_t e;
    if (bus.lfsr_reset === 1'b1) begin
      len_cnt = 0;
      flush_seen = 1'b0;
    end else begin
      if (bus.lfsr_enable === 1'b1) len_cnt++;
      if (bus.misr_enable === 1'b1 && bus.lfsr_enable === 1'b0) flush_seen = 1'b1;
    end
    if (bus.done === 1'b1 && done_prev == 1'b0) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("latency", cyc - e.start_cyc, e.lat);
        chk("pass", bus.pass, e.pass);
        chk("error", bus.error, e.err);
        chk("busy_in_done", bus.busy, 0);
        if (e.chk_cnt) chk("pattern_cnt", bus.pattern_cnt, e.cnt);
        chk("lfsr_en_cycles", len_cnt, e.len);
        chk("flush_seen", flush_seen, e.flush);
      end
    end
    done_prev = (bus.done === 1'b1);
  end

  initial begin
    reset = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.lfsr_x = 7'h01;
    bus.misr_sig = GOLD;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_outs", outs(), 0);

    // Nominal run, start held into INIT/RUN without changing the timing.
    push_run(NP + 4, 1'b1, 1'b0, 1'b1, NP - 1, NP, 1'b1);
    bus.start = 1'b1;
    repeat (5) @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    chk("done_hold", {bus.done, bus.pass, bus.busy, bus.test_mode, bus.pattern_cnt}, {4'b1100, 7'd126});

    // Rerun from DONE with a mismatching signature.
    bus.misr_sig = 7'h2B;
    push_run(NP + 4, 1'b0, 1'b0, 1'b1, NP - 1, NP, 1'b1);
    bus.start = 1'b1;
    @(negedge clk);
    chk("init_flags", {bus.done, bus.pass, bus.error, bus.lfsr_reset, bus.misr_reset,
                       bus.busy, bus.test_mode, bus.lfsr_enable}, 8'b00011110);
    chk("init_cnt", bus.pattern_cnt, 0);
    bus.start = 1'b0;
    @(negedge clk);
    chk("run1_flags", {bus.lfsr_reset, bus.misr_reset, bus.lfsr_enable, bus.misr_enable}, 4'b0011);
    wait_done();

    // Lock-up on the 10th RUN cycle.
    bus.misr_sig = GOLD;
    push_run(12, 1'b0, 1'b1, 1'b0, 0, 10, 1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("run10_cnt", bus.pattern_cnt, 9);
    bus.lfsr_x = 7'h00;
    @(negedge clk);
    bus.lfsr_x = 7'h5A;
    wait_done();

    // Rerun clears error; abort on RUN cycle 50 together with lock-up.
    bus.start = 1'b1;
    @(negedge clk);
    chk("rerun_clears", {bus.done, bus.pass, bus.error}, 3'b000);
    bus.start = 1'b0;
    repeat (50) @(negedge clk);
    chk("run50_cnt", bus.pattern_cnt, 49);
    bus.abort = 1'b1;
    bus.lfsr_x = 7'h00;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.lfsr_x = 7'h5A;
    chk("abort_outs", outs(), 0);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_idle", outs(), 0);

    // Full run after abort.
    push_run(NP + 4, 1'b1, 1'b0, 1'b1, NP - 1, NP, 1'b1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    // Reset during RUN with start and abort also asserted.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (30) @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("reset_midrun_outs", outs(), 0);
    @(negedge clk);
    chk("after_reset_idle", outs(), 0);

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
